// File: rtl/alu_seq.sv
// ALU transfer initiator: loads operands A and B over a valid/ready handshake,
// then drives the ALU for one cycle and captures the bus result and carry.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seq_start,
    input  logic             seq_sub,
    input  logic             seq_abort,
    input  logic [WIDTH-1:0] seq_din,
    input  logic             seq_din_valid,
    output logic             seq_din_ready,
    output logic [WIDTH-1:0] seq_a,
    output logic [WIDTH-1:0] seq_b,
    output logic             seq_alu_out,
    output logic             seq_alu_cut,
    input  logic [WIDTH-1:0] seq_bus,
    input  logic             seq_alu_cy,
    output logic [WIDTH-1:0] seq_result,
    output logic             seq_cy,
    output logic             seq_zero,
    output logic             seq_busy,
    output logic             seq_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        DONE
    } state_t;

    state_t state, state_nx;
    logic   op_sub;
    logic   xfer;

    assign xfer = seq_din_valid & seq_din_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Abort overrides every transition, including acceptance of a new start.
    always_comb begin
        state_nx = state;
        if (seq_abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (seq_start) state_nx = LOAD_A;
                LOAD_A:  if (xfer)      state_nx = LOAD_B;
                LOAD_B:  if (xfer)      state_nx = EXEC;
                EXEC:                   state_nx = DONE;
                DONE:                   state_nx = IDLE;
                default:                state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_sub     <= 1'b0;
            seq_a      <= '0;
            seq_b      <= '0;
            seq_result <= '0;
            seq_cy     <= 1'b0;
            seq_zero   <= 1'b0;
        end else if (!seq_abort) begin
            case (state)
                IDLE:   if (seq_start) op_sub <= seq_sub;
                LOAD_A: if (xfer)      seq_a  <= seq_din;
                LOAD_B: if (xfer)      seq_b  <= seq_din;
                EXEC: begin
                    seq_result <= seq_bus;
                    seq_cy     <= seq_alu_cy;
                    seq_zero   <= (seq_bus == '0);
                end
                default: ;
            endcase
        end
    end

    assign seq_din_ready = (state == LOAD_A) || (state == LOAD_B);
    assign seq_alu_out   = (state == EXEC);
    assign seq_alu_cut   = (state == EXEC) && op_sub;
    assign seq_done      = (state == DONE);
    assign seq_busy      = (state != IDLE);

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Initiator for the ALU bus transfer: loads operand registers A and B from a data handshake, then commands the ALU for one cycle.
- During that cycle it asserts output-enable and subtract and captures the bus result and carry into a result/flag register.
- Sits between the control sequencer and the ALU. It drives the ALU's A/B inputs, output-enable and subtract lines, and receives the ALU's bus value and carry.

Parameters:
- WIDTH, 8, datapath width of operands, bus and result.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- seq_start  input  1  request a new operation; accepted only in IDLE
- seq_sub  input  1  operation select, latched with seq_start: 0 = add, 1 = subtract
- seq_abort  input  1  return to IDLE from any state on next edge
- seq_din  input  WIDTH  operand data
- seq_din_valid  input  1  seq_din holds a valid operand
- seq_din_ready  output  1  block accepts an operand this cycle
- seq_a  output  WIDTH  operand A to ALU, held from capture until next capture
- seq_b  output  WIDTH  operand B to ALU, same hold rule
- seq_alu_out  output  1  ALU bus output-enable
- seq_alu_cut  output  1  ALU subtract select
- seq_bus  input  WIDTH  shared bus value, valid while seq_alu_out = 1
- seq_alu_cy  input  1  ALU carry
- seq_result  output  WIDTH  captured result
- seq_cy  output  1  captured carry
- seq_zero  output  1  captured result == 0
- seq_busy  output  1  state != IDLE
- seq_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n = 0 at an edge):
  - state goes to IDLE.
  - seq_a, seq_b, seq_result = 0.
  - seq_cy, seq_zero, seq_alu_out, seq_alu_cut, seq_done, seq_din_ready, seq_busy = 0.
  - Reset mid-operation discards everything, and no seq_done is issued.
- States: IDLE, LOAD_A, LOAD_B, EXEC, DONE. Encoding is free, but all outputs are registered or decoded from state only.
- IDLE:
  - On seq_start = 1, latch seq_sub into an op register and go to LOAD_A.
  - seq_start in any other state is ignored.
- LOAD_A:
  - seq_din_ready = 1.
  - A transfer happens on an edge where valid & ready: seq_a <= seq_din, go to LOAD_B.
  - With no valid, stay in LOAD_A indefinitely.
- LOAD_B: same handshake, seq_b <= seq_din, go to EXEC.
- EXEC (exactly one cycle):
  - seq_alu_out = 1 and seq_alu_cut = latched op; seq_din_ready = 0.
  - At the closing edge: seq_result <= seq_bus, seq_cy <= seq_alu_cy, seq_zero <= (seq_bus == 0).
  - Go to DONE.
- DONE (one cycle): seq_done = 1, then go to IDLE.
- seq_start is not accepted in DONE. The earliest restart is the first IDLE cycle.
- seq_alu_out and seq_alu_cut are 0 outside EXEC; the block never enables the ALU onto the bus otherwise.
- seq_result, seq_cy and seq_zero hold their values until the next EXEC capture or reset.
- Latency, with seq_din_valid held high:
  - start sampled at edge 0;
  - A captured edge 1, B captured edge 2;
  - EXEC cycle between edges 2 and 3, result captured edge 3;
  - seq_done high between edges 3 and 4;
  - busy from edge 0 to edge 4.
- Abort:
  - seq_abort = 1 in any non-IDLE state goes to IDLE at the next edge.
  - seq_a and seq_b keep any already-captured value; result and flags are unchanged; no seq_done.
  - If abort arrives in EXEC, the capture at that edge is suppressed.
  - Abort and a valid handshake on the same edge: abort wins and the operand is not captured.
- Arithmetic is performed only by the ALU. The block passes the carry through and never recomputes it; the result is WIDTH bits with no wrap handling inside.
- Simultaneous events:
  - reset has priority over abort;
  - abort has priority over all state transitions.

Test Plan:
- Add: start (sub = 0), operands 10 then 10, valid held high → seq_alu_out high exactly one cycle with seq_alu_cut = 0; seq_result = 20, seq_cy = 0, seq_zero = 0; seq_done pulse 4 cycles after start.
- Overflow: 200 + 100 → seq_result = 44, seq_cy = 1, seq_zero = 0.
- Subtract: sub = 1, 10 − 10 → seq_alu_cut = 1 only during EXEC; seq_result = 0, seq_zero = 1; seq_cy equals ALU carry sampled in EXEC.
- Stalled handshake: valid low for 5 cycles in LOAD_A, then operands 7 and 3 → state holds and seq_din_ready stays 1 while stalled; result 10 once valid arrives.
- Abort in LOAD_B after A = 55 → IDLE next cycle, no done, seq_a = 55, previous result and flags unchanged; a new start is accepted immediately.
- Reset: rst_n low during EXEC → all outputs 0 at next edge, no capture, no done; seq_start during busy and in DONE is ignored.
